// File: rtl/ahb_lite_mem_tester.sv
// AHB-Lite bus master for SDRAM bring-up: pipelined pattern write, wait, read-back check.
// Reports mismatch/error-response counts and the first failing word.
module ahb_lite_mem_tester #(
    parameter logic [31:0] ADDR_INCREMENT = 32'h10004,
    parameter int unsigned WORD_COUNT     = 9,
    parameter int unsigned DELAY_BITS     = 10,
    parameter int unsigned READ_ITER_CNT  = 3,
    parameter bit          CONTINUOUS     = 1'b0
) (
    input  logic        HCLK,
    input  logic        HRESET,
    output logic [31:0] HADDR,
    output logic [2:0]  HBURST,
    output logic        HSEL,
    output logic [2:0]  HSIZE,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [31:0] HWDATA,
    input  logic [31:0] HRDATA,
    input  logic        HREADY,
    input  logic        HRESP,
    input  logic        START,
    input  logic [1:0]  MODE,
    input  logic [31:0] STARTADDR,
    input  logic [31:0] SEED,
    output logic        BUSY,
    output logic        S_WRITE,
    output logic        S_CHECK,
    output logic        S_SUCCESS,
    output logic        S_FAILED,
    output logic [31:0] ERRCOUNT,
    output logic [15:0] RESPCOUNT,
    output logic [7:0]  CHKCOUNT,
    output logic [31:0] FIRST_ERR_ADDR,
    output logic [31:0] FIRST_ERR_DATA,
    output logic        FIRST_ERR_VALID
);

    localparam int unsigned IDX_W = (WORD_COUNT > 1) ? $clog2(WORD_COUNT) : 1;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_WRITE = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_READ  = 3'd3;
    localparam logic [2:0] ST_DRAIN = 3'd4;
    localparam logic [2:0] ST_PASS  = 3'd5;
    localparam logic [2:0] ST_FAIL  = 3'd6;

    logic [2:0]            state, state_nx;
    logic                  dp_valid, dp_write;
    logic [31:0]           dp_addr, dp_pat;
    logic [IDX_W-1:0]      word_idx;
    logic [31:0]           lfsr, walk, start_q, seed_q;
    logic [1:0]            mode_q;
    logic [DELAY_BITS-1:0] wait_cnt;
    logic                  rerun;

    logic        go_c, last_c, done_c, wait_done_c, chk_last_c, fail_c;
    logic [31:0] pat_c, lfsr_nx_c, seed_fix_c;

    assign HBURST = 3'b000;
    assign HSEL   = 1'b1;
    assign HSIZE  = 3'b010;

    assign go_c        = START || rerun;
    assign last_c      = (word_idx == IDX_W'(WORD_COUNT - 1));
    assign done_c      = HREADY && !HTRANS[1] && dp_valid;
    assign wait_done_c = &wait_cnt;
    assign chk_last_c  = (CHKCOUNT == 8'(READ_ITER_CNT - 1));
    assign fail_c      = (ERRCOUNT != 32'd0) || (RESPCOUNT != 16'd0);
    assign seed_fix_c  = (SEED == 32'd0) ? 32'd1 : SEED;
    assign lfsr_nx_c   = {lfsr[30:0], lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0]};

    // Pattern of the word currently presented in the address phase
    always_comb begin
        pat_c = walk;
        case (mode_q)
            2'd0:    pat_c = HADDR;
            2'd1:    pat_c = ~HADDR;
            2'd2:    pat_c = lfsr;
            default: pat_c = walk;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (go_c) state_nx = ST_WRITE;
            ST_WRITE: if (done_c) state_nx = ST_WAIT;
            ST_WAIT:  if (wait_done_c) state_nx = ST_READ;
            ST_READ:  if (done_c) state_nx = ST_DRAIN;
            ST_DRAIN: begin
                if (chk_last_c) state_nx = fail_c ? ST_FAIL : ST_PASS;
                else            state_nx = ST_WAIT;
            end
            ST_PASS, ST_FAIL: if (CONTINUOUS) state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            HADDR           <= '0;
            HTRANS          <= 2'b00;
            HWRITE          <= 1'b0;
            HWDATA          <= '0;
            BUSY            <= 1'b0;
            S_WRITE         <= 1'b0;
            S_CHECK         <= 1'b0;
            S_SUCCESS       <= 1'b0;
            S_FAILED        <= 1'b0;
            ERRCOUNT        <= '0;
            RESPCOUNT       <= '0;
            CHKCOUNT        <= '0;
            FIRST_ERR_ADDR  <= '0;
            FIRST_ERR_DATA  <= '0;
            FIRST_ERR_VALID <= 1'b0;
            dp_valid        <= 1'b0;
            dp_write        <= 1'b0;
            dp_addr         <= '0;
            dp_pat          <= '0;
            word_idx        <= '0;
            lfsr            <= '0;
            walk            <= '0;
            mode_q          <= '0;
            start_q         <= '0;
            seed_q          <= '0;
            wait_cnt        <= '0;
            rerun           <= 1'b0;
        end else begin
            BUSY      <= (state_nx == ST_WRITE) || (state_nx == ST_WAIT) ||
                         (state_nx == ST_READ)  || (state_nx == ST_DRAIN);
            S_WRITE   <= (state_nx == ST_WRITE);
            S_CHECK   <= (state_nx == ST_WAIT) || (state_nx == ST_READ) ||
                         (state_nx == ST_DRAIN);
            S_SUCCESS <= (state_nx == ST_PASS);
            S_FAILED  <= (state_nx == ST_FAIL);
            rerun     <= CONTINUOUS && ((state == ST_PASS) || (state == ST_FAIL));
            wait_cnt  <= (state == ST_WAIT) ? wait_cnt + DELAY_BITS'(1) : '0;

            case (state)
                ST_IDLE: if (go_c) begin
                    mode_q          <= MODE;
                    start_q         <= STARTADDR;
                    seed_q          <= seed_fix_c;
                    ERRCOUNT        <= '0;
                    RESPCOUNT       <= '0;
                    CHKCOUNT        <= '0;
                    FIRST_ERR_ADDR  <= '0;
                    FIRST_ERR_DATA  <= '0;
                    FIRST_ERR_VALID <= 1'b0;
                    HADDR           <= STARTADDR;
                    HTRANS          <= 2'b10;
                    HWRITE          <= 1'b1;
                    word_idx        <= '0;
                    lfsr            <= seed_fix_c;
                    walk            <= 32'd1;
                end
                ST_WAIT: if (wait_done_c) begin
                    HADDR    <= start_q;
                    HTRANS   <= 2'b10;
                    HWRITE   <= 1'b0;
                    word_idx <= '0;
                    lfsr     <= seed_q;
                    walk     <= 32'd1;
                end
                ST_WRITE, ST_READ: if (HREADY) begin
                    // Data phase of the previous word completes on this edge
                    if (dp_valid) begin
                        if (HRESP) begin
                            if (RESPCOUNT != '1) RESPCOUNT <= RESPCOUNT + 16'd1;
                        end else if (!dp_write && (HRDATA != dp_pat)) begin
                            if (ERRCOUNT != '1) ERRCOUNT <= ERRCOUNT + 32'd1;
                            if (!FIRST_ERR_VALID) begin
                                FIRST_ERR_ADDR  <= dp_addr;
                                FIRST_ERR_DATA  <= HRDATA;
                                FIRST_ERR_VALID <= 1'b1;
                            end
                        end
                    end
                    // Address phase accepted: it becomes the next data phase
                    if (HTRANS[1]) begin
                        dp_valid <= 1'b1;
                        dp_write <= HWRITE;
                        dp_addr  <= HADDR;
                        dp_pat   <= pat_c;
                        if (HWRITE) HWDATA <= pat_c;
                        if (last_c) begin
                            HTRANS <= 2'b00;
                        end else begin
                            word_idx <= word_idx + IDX_W'(1);
                            HADDR    <= HADDR + ADDR_INCREMENT;
                            lfsr     <= lfsr_nx_c;
                            walk     <= {walk[30:0], walk[31]};
                        end
                    end else begin
                        dp_valid <= 1'b0;
                    end
                end
                ST_DRAIN: CHKCOUNT <= CHKCOUNT + 8'd1;
                default: ;
            endcase
        end
    end

endmodule
